// File: rtl/capture_buffer_ctrl.sv
// Capture write controller: streams probe samples into a ring buffer before and after a trigger.
// Define CAPTURE_DIVIDER_EN to add the divisor port and the sample-rate divider.
module capture_buffer_ctrl #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 10
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              idle,
    input  logic              running,
    input  logic              triggered,
    input  logic [DATA_W-1:0] sampleIn,
    input  logic [ADDR_W-1:0] postCount,
`ifdef CAPTURE_DIVIDER_EN
    input  logic [15:0]       divisor,
`endif
    output logic              memWe,
    output logic [ADDR_W-1:0] memAddr,
    output logic [DATA_W-1:0] memData,
    output logic              complete,
    output logic [ADDR_W-1:0] trigAddr,
    output logic              wrapped,
    output logic [1:0]        dbgState
);

    typedef enum logic [1:0] {
        ST_WAIT = 2'd0,
        ST_PRE  = 2'd1,
        ST_POST = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] post_cnt_q, post_cnt_d;
    logic [ADDR_W-1:0] post_target_q, post_target_d;
    logic [ADDR_W-1:0] trig_addr_q, trig_addr_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_data_q, mem_data_d;
    logic              mem_we_q, mem_we_d;
    logic              complete_q, complete_d;
    logic              wrapped_q, wrapped_d;
    logic              sampling;
    logic              div_tick;
    logic              strobe;

`ifdef CAPTURE_DIVIDER_EN
    logic [15:0] div_cnt_q, div_cnt_d;
    logic [15:0] divisor_q, divisor_d;

    assign div_tick = (div_cnt_q == 16'd0);
`else
    assign div_tick = 1'b1;
`endif

    assign sampling = (state_q == ST_PRE || state_q == ST_POST) && !idle;
    // A zero-length post window completes straight away and must not store a sample.
    assign strobe   = sampling && div_tick && !(state_q == ST_POST && post_target_q == '0);

    always_comb begin
        state_d       = state_q;
        wr_ptr_d      = wr_ptr_q;
        post_cnt_d    = post_cnt_q;
        post_target_d = post_target_q;
        trig_addr_d   = trig_addr_q;
        mem_addr_d    = mem_addr_q;
        mem_data_d    = mem_data_q;
        wrapped_d     = wrapped_q;
        mem_we_d      = 1'b0;
        complete_d    = 1'b0;

        if (strobe) begin
            mem_we_d   = 1'b1;
            mem_addr_d = wr_ptr_q;
            mem_data_d = sampleIn;
            wr_ptr_d   = wr_ptr_q + 1'b1;
            if (wr_ptr_q == '1) begin
                wrapped_d = 1'b1;
            end
        end

        case (state_q)
            ST_WAIT: begin
                if (triggered) begin
                    state_d       = ST_POST;
                    post_target_d = postCount;
                end else if (running) begin
                    state_d = ST_PRE;
                end
            end
            ST_PRE: begin
                if (idle) begin
                    state_d = ST_WAIT;
                end else if (triggered) begin
                    state_d       = ST_POST;
                    post_target_d = postCount;
                end
            end
            ST_POST: begin
                if (idle) begin
                    state_d = ST_WAIT;
                end else if (post_target_q == '0) begin
                    complete_d  = 1'b1;
                    trig_addr_d = wr_ptr_q;
                    state_d     = ST_DONE;
                end else if (strobe) begin
                    if (post_cnt_q == '0) begin
                        trig_addr_d = wr_ptr_q;
                    end
                    post_cnt_d = post_cnt_q + 1'b1;
                    if (post_cnt_d == post_target_q) begin
                        complete_d = 1'b1;
                        state_d    = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                if (idle) begin
                    state_d = ST_WAIT;
                end
            end
            default: state_d = ST_WAIT;
        endcase

        // Pointer, post count and wrap flag read as zero for the whole time spent waiting.
        if (state_d == ST_WAIT) begin
            wr_ptr_d   = '0;
            post_cnt_d = '0;
            wrapped_d  = 1'b0;
        end
    end

`ifdef CAPTURE_DIVIDER_EN
    always_comb begin
        divisor_d = divisor_q;
        div_cnt_d = 16'd0;
        if (state_q == ST_WAIT && state_d != ST_WAIT) begin
            divisor_d = divisor;
        end
        // The phase keeps running across the trigger so the sample spacing stays uniform.
        if ((state_q == ST_PRE || state_q == ST_POST) &&
            (state_d == ST_PRE || state_d == ST_POST)) begin
            div_cnt_d = (div_cnt_q >= divisor_q) ? 16'd0 : div_cnt_q + 16'd1;
        end
    end
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= ST_WAIT;
            wr_ptr_q      <= '0;
            post_cnt_q    <= '0;
            post_target_q <= '0;
            trig_addr_q   <= '0;
            mem_addr_q    <= '0;
            mem_data_q    <= '0;
            mem_we_q      <= 1'b0;
            complete_q    <= 1'b0;
            wrapped_q     <= 1'b0;
`ifdef CAPTURE_DIVIDER_EN
            div_cnt_q     <= 16'd0;
            divisor_q     <= 16'd0;
`endif
        end else begin
            state_q       <= state_d;
            wr_ptr_q      <= wr_ptr_d;
            post_cnt_q    <= post_cnt_d;
            post_target_q <= post_target_d;
            trig_addr_q   <= trig_addr_d;
            mem_addr_q    <= mem_addr_d;
            mem_data_q    <= mem_data_d;
            mem_we_q      <= mem_we_d;
            complete_q    <= complete_d;
            wrapped_q     <= wrapped_d;
`ifdef CAPTURE_DIVIDER_EN
            div_cnt_q     <= div_cnt_d;
            divisor_q     <= divisor_d;
`endif
        end
    end

    assign memWe    = mem_we_q;
    assign memAddr  = mem_addr_q;
    assign memData  = mem_data_q;
    assign complete = complete_q;
    assign trigAddr = trig_addr_q;
    assign wrapped  = wrapped_q;
    assign dbgState = state_q;

endmodule

// File: doc/capture_buffer_ctrl.md
CAPTURE_BUFFER_CTRL -- requirements
Module: capture_buffer_ctrl

Interface
REQ-001 Parameter: DATA_W, default 16, width of the sample word.
REQ-002 Parameter: ADDR_W, default 10, sample buffer address width (depth 2^ADDR_W).
REQ-003 Port: clock  in  1  system clock; all logic on rising edge.
REQ-004 Port: reset  in  1  synchronous, active-high reset.
REQ-005 Port: idle  in  1  analyzer control, no capture active.
REQ-006 Port: running  in  1  analyzer control, sampling pre-trigger.
REQ-007 Port: triggered  in  1  analyzer control, sampling post-trigger.
REQ-008 Port: sampleIn  in  DATA_W  probe sample word.
REQ-009 Port: postCount  in  ADDR_W  number of post-trigger samples to store.
REQ-010 Port: divisor  in  16  sample divider; present only with CAPTURE_DIVIDER_EN.
REQ-011 Port: memWe  out  1  buffer RAM write enable.
REQ-012 Port: memAddr  out  ADDR_W  buffer RAM write address.
REQ-013 Port: memData  out  DATA_W  buffer RAM write data.
REQ-014 Port: complete  out  1  one-cycle pulse: post-trigger quota stored; drives the analyzer control block's complete input.
REQ-015 Port: trigAddr  out  ADDR_W  buffer address of first post-trigger sample.
REQ-016 Port: wrapped  out  1  write pointer has wrapped at least once this capture.

Function
REQ-017 Internal FSM states SHALL be WAIT, PRE, POST, DONE.
REQ-018 WAIT->PRE when running & ~triggered; WAIT->POST when triggered; otherwise hold.
REQ-019 PRE->POST when triggered; PRE->WAIT when idle (abort, no complete).
REQ-020 POST->DONE when the postCount-th post-trigger sample is written; POST->WAIT when idle before that (abort, no complete).
REQ-021 DONE->WAIT when idle; no writes in DONE.
REQ-022 If running and triggered are both high, triggered SHALL take priority.
REQ-023 Sample strobe SHALL occur every cycle in PRE/POST (divider rules in REQ-036).
REQ-024 On a strobe, the next cycle SHALL present memWe=1, memAddr=wrPtr, memData=sampleIn as registered at the strobe (one-cycle latency); memWe=0 otherwise.
REQ-025 wrPtr SHALL increment by 1 per strobe, wrapping 2^ADDR_W-1 -> 0; wrapped SHALL set on that wrap and stay set until WAIT is re-entered.
REQ-026 On the first strobe in POST, trigAddr SHALL latch wrPtr; trigAddr SHALL hold through WAIT for readout.
REQ-027 Post counter SHALL count POST strobes; complete SHALL pulse high in the same cycle as memWe for the postCount-th post sample.
REQ-028 postCount=0: complete SHALL pulse the cycle after POST entry, with no post-trigger write and trigAddr latched to current wrPtr.
REQ-029 complete SHALL be high for exactly one cycle per capture.
REQ-030 In WAIT, wrPtr, post counter and wrapped SHALL be held at 0.
REQ-031 postCount SHALL be sampled on POST entry; later changes are ignored until the next capture.

Reset
REQ-032 reset SHALL force state WAIT and wrPtr, post counter, divider counter, memWe, memAddr, memData, complete, trigAddr and wrapped to 0.
REQ-033 reset mid-capture SHALL abort with no complete pulse and no further writes from the next cycle.

Configuration
REQ-034 Macro CAPTURE_DIVIDER_EN SHALL select the sample-rate divider.
REQ-035 Without CAPTURE_DIVIDER_EN: no divisor port; strobe every PRE/POST cycle.
REQ-036 With CAPTURE_DIVIDER_EN: 16-bit counter counts 0..divisor in PRE/POST, strobe when counter=0, cleared in WAIT/DONE; divisor=0 SHALL equal no division; divisor sampled on WAIT exit.

Verification
REQ-037 ADDR_W=4, running 3 cycles, triggered, postCount=5 -> 8 writes at addresses 0..7, trigAddr=3, complete with write at address 7, wrapped=0.
REQ-038 ADDR_W=4, running 20 cycles, then triggered, postCount=2 -> addresses wrap 15->0, wrapped=1, trigAddr=4, complete with write at address 5.
REQ-039 postCount=0, trigger after 2 PRE cycles -> no post write, complete one cycle after POST entry, trigAddr=2.
REQ-040 idle asserted in POST after 2 of 10 post samples -> memWe low next cycle, no complete, wrPtr=0.
REQ-041 reset during PRE, then new capture -> writes restart at address 0, wrapped=0.
REQ-042 CAPTURE_DIVIDER_EN, divisor=2, postCount=3 -> one write every 3 cycles, complete 7 cycles after first POST strobe.
